// File: rtl/crossbar_arbiter.sv
// crossbar_arbiter: round-robin egress arbiter that grants one crossbar point and muxes its AXI-Stream packet out.
module crossbar_arbiter #(
    parameter int          P_SRC_NUM = 8,
    parameter logic [15:0] P_TIMEOUT = 16'd64,
    localparam int         SW        = $clog2(P_SRC_NUM)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [P_SRC_NUM-1:0]    i_trans_req,
    output logic [P_SRC_NUM-1:0]    o_trans_grant,
    input  logic [P_SRC_NUM-1:0]    s_axis_tvalid,
    input  logic [64*P_SRC_NUM-1:0] s_axis_tdata,
    input  logic [P_SRC_NUM-1:0]    s_axis_tlast,
    input  logic [8*P_SRC_NUM-1:0]  s_axis_tkeep,
    output logic [P_SRC_NUM-1:0]    s_axis_tready,
    output logic                    m_axis_tx_tvalid,
    output logic [63:0]             m_axis_tx_tdata,
    output logic                    m_axis_tx_tlast,
    output logic [7:0]              m_axis_tx_tkeep,
    output logic                    m_axis_tx_tuser,
    input  logic                    m_axis_tx_tready,
    output logic                    o_busy,
    output logic [SW-1:0]           o_grant_id,
    output logic                    o_timeout,
    output logic [15:0]             o_pkt_cnt
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT, BUSY} state_t;
    localparam logic [SW:0] PN = (SW+1)'(P_SRC_NUM);
    state_t          state, state_n;
    logic [SW-1:0]   r_ptr, r_sel, nsel;
    logic [SW-1:0]   cand [P_SRC_NUM];
    logic [15:0]     r_to_cnt;
    logic            found, active, sel_valid, pkt_done, to_hit;
    // cand[k] is the k-th source after r_ptr, wrapped modulo P_SRC_NUM
    for (genvar k = 0; k < P_SRC_NUM; k++) begin : g_cand
        logic [SW:0] sum;
        assign sum     = {1'b0, r_ptr} + (SW+1)'(k + 1);
        assign cand[k] = sum >= PN ? SW'(sum - PN) : SW'(sum);
    end
    always_comb begin
        found = 1'b0;
        nsel  = r_ptr;
        for (int k = P_SRC_NUM - 1; k >= 0; k--) begin
            if (i_trans_req[cand[k]]) begin
                found = 1'b1;
                nsel  = cand[k];
            end
        end
    end
    assign active           = state == WAIT || state == BUSY;
    assign sel_valid        = s_axis_tvalid[r_sel];
    assign m_axis_tx_tvalid = active & sel_valid;
    assign m_axis_tx_tdata  = active ? s_axis_tdata[64*r_sel +: 64] : 64'd0;
    assign m_axis_tx_tlast  = active & s_axis_tlast[r_sel];
    assign m_axis_tx_tkeep  = active ? s_axis_tkeep[8*r_sel +: 8] : 8'hFF;
    assign m_axis_tx_tuser  = 1'b0;
    assign s_axis_tready    = active ? P_SRC_NUM'(m_axis_tx_tready) << r_sel : '0;
    assign pkt_done         = m_axis_tx_tvalid & m_axis_tx_tready & m_axis_tx_tlast;
    assign to_hit           = state == WAIT && !sel_valid && r_to_cnt == P_TIMEOUT - 16'd1;
    assign o_timeout        = to_hit;
    assign o_busy           = active;
    assign o_grant_id       = r_sel;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? GRANT : IDLE;
            GRANT:   state_n = WAIT;
            WAIT:    state_n = pkt_done ? IDLE : sel_valid ? BUSY : to_hit ? IDLE : WAIT;
            default: state_n = pkt_done ? IDLE : BUSY;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            r_ptr         <= SW'(P_SRC_NUM - 1);
            r_sel         <= '0;
            o_trans_grant <= '0;
            r_to_cnt      <= '0;
            o_pkt_cnt     <= '0;
        end else begin
            state         <= state_n;
            o_trans_grant <= (state == IDLE && found) ? P_SRC_NUM'(1) << nsel : '0;
            if (state == IDLE && found) begin
                r_sel <= nsel;
                r_ptr <= nsel;
            end
            r_to_cnt <= state == WAIT ? r_to_cnt + 16'd1 : 16'd0;
            if (pkt_done && o_pkt_cnt != 16'hFFFF)
                o_pkt_cnt <= o_pkt_cnt + 16'd1;
        end
    end
endmodule

// File: doc/crossbar_arbiter.md
# crossbar_arbiter

Output-side arbiter of the crossbar: one instance per egress port. It collects `o_trans_req` from every `crossbar_point` feeding this port and issues a one-cycle `i_trans_grant` pulse to one of them, chosen by round-robin. It then muxes the granted point's AXI-Stream packet onto the single egress stream until `tlast` is accepted. Back-pressure from the egress reaches the granted point only.

## Interface
- `P_SRC_NUM`, default 8: number of requesting crossbar points. `SW = $clog2(P_SRC_NUM)`.
- `P_TIMEOUT`, default 16'd64: maximum cycles to wait for the first beat after a grant.
- `i_clk` in 1: single clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_trans_req` in P_SRC_NUM: level request from each point; bit i belongs to point i.
- `o_trans_grant` out P_SRC_NUM: one-hot, one-cycle grant pulse.
- `s_axis_tvalid` in P_SRC_NUM: per-source valid.
- `s_axis_tdata` in 64*P_SRC_NUM: source i occupies bits [64i+63:64i].
- `s_axis_tlast` in P_SRC_NUM: per-source last.
- `s_axis_tkeep` in 8*P_SRC_NUM: source i occupies bits [8i+7:8i].
- `s_axis_tready` out P_SRC_NUM: per-source ready.
- `m_axis_tx_tvalid`, `m_axis_tx_tdata`[64], `m_axis_tx_tlast`, `m_axis_tx_tkeep`[8], `m_axis_tx_tuser` out: egress stream. `m_axis_tx_tuser` is constant 0.
- `m_axis_tx_tready` in 1: egress ready.
- `o_busy` out 1: high in WAIT and BUSY.
- `o_grant_id` out SW: currently or last selected source.
- `o_timeout` out 1: one-cycle pulse when a grant times out.
- `o_pkt_cnt` out 16: count of forwarded packets. Saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, GRANT, WAIT, BUSY.
- **IDLE.** If `i_trans_req != 0`, search from `r_ptr+1` upward with modulo-P_SRC_NUM wrap. Take the first set bit as `r_sel`, set `r_ptr <= r_sel`, and go to GRANT. With no requests, stay in IDLE.
- **GRANT.** `o_trans_grant` is registered and equals one-hot(`r_sel`) for exactly this cycle. Next state is WAIT. `i_trans_req` is ignored from GRANT until the FSM returns to IDLE.
- **WAIT.** The mux is active. `r_to_cnt` increments each cycle.
  - If `s_axis_tvalid[r_sel]` is high, go to BUSY.
  - If `s_axis_tvalid[r_sel]` is high and `s_axis_tlast[r_sel]` and `m_axis_tx_tready` are high in the same cycle, go straight to IDLE and count the packet.
  - If `r_to_cnt == P_TIMEOUT-1` with no valid, go to IDLE and pulse `o_timeout`.
- **BUSY.** The mux is active with no timeout; stalls are legal.
  - Leave on handshake: `m_axis_tx_tvalid && m_axis_tx_tready && m_axis_tx_tlast`. Go to IDLE and increment `o_pkt_cnt` (saturating).
- **Mux (combinational) while WAIT or BUSY:**
  - `m_axis_tx_tvalid/tdata/tlast/tkeep` = source `r_sel` fields.
  - `s_axis_tready[r_sel] = m_axis_tx_tready`.
  - All other `s_axis_tready` bits are 0.
- **Outside WAIT and BUSY:** `m_axis_tx_tvalid = 0`, `m_axis_tx_tlast = 0`, `m_axis_tx_tdata = 0`, `m_axis_tx_tkeep = 8'hFF`, `s_axis_tready = 0`.
- **Boundary rules:**
  - A request that rises in the same cycle as the tlast handshake is evaluated in the following IDLE cycle.
  - A source keeping its request high after being served is re-granted only after every other requester has been served once.
  - A source whose request drops before it is granted is skipped.
  - Reset mid-packet aborts the packet. The next grant starts a fresh packet, and the point is responsible for its own recovery.

## Timing
- **Reset values:** state IDLE, `r_ptr = P_SRC_NUM-1` (so the first search starts at source 0), `r_sel = 0`, `o_trans_grant = 0`, `o_busy = 0`, `o_grant_id = 0`, `o_timeout = 0`, `o_pkt_cnt = 0`. Stream outputs take their IDLE values.
- **Request to grant:** a request sampled in IDLE at cycle t gives the grant pulse at t+1. The mux is active from t+2.
- **Packet end to next grant:** tlast handshake at cycle t gives IDLE at t+1 and the earliest next grant at t+2.
- **Throughput:** the egress path adds zero latency; data, valid and ready are combinational through the mux.
- **Timeout:** the grant is at cycle g. With no valid beat, `o_timeout` pulses at g+P_TIMEOUT and state is IDLE at g+P_TIMEOUT+1.
- **Widths:** `r_to_cnt` is 16 bits and is cleared on entry to WAIT. The pointer arithmetic is SW bits wide with explicit modulo wrap for non-power-of-2 `P_SRC_NUM`.

## Test plan
- **Single source:** req[3]=1 and a 4-beat packet with last tkeep 8'h0F.
  - `o_trans_grant` = 8'h08 for 1 cycle.
  - Egress carries 4 beats, tlast on beat 4 with tkeep 8'h0F.
  - `o_pkt_cnt` = 1.
- **Simultaneous requests:** req = 8'h21 from reset.
  - Grants go to 0 then 5.
  - The source-5 grant follows source-0's tlast handshake by exactly 2 cycles.
- **Fairness:** all 8 requests held high, each source sending 2-beat packets.
  - Grant order is 0,1,...,7,0.
  - No source receives two grants within any 8 consecutive grants.
- **Backpressure:** `m_axis_tx_tready` toggles 1010 during a 6-beat packet from source 2.
  - Data order is preserved with no beat lost or duplicated.
  - `s_axis_tready[2]` mirrors `m_axis_tx_tready`; all other tready bits stay 0.
- **Timeout:** source 6 is granted but never asserts valid, with `P_TIMEOUT`=64.
  - `o_timeout` pulses 64 cycles after the grant.
  - A pending req[7] is granted 2 cycles later.
- **Reset mid-packet:** `i_rst` is asserted at beat 3 of 8 from source 1.
  - The next cycle shows all outputs at reset values and `s_axis_tready` = 0.
  - After release, req[1] is granted first because `r_ptr` resets to 7.
